// File: rtl/escalonador_contexto.sv
// escalonador_contexto: round-robin process scheduler with per-slot saved PC and state table.
// Build with ESCALONADOR_STATS_EN defined to add per-slot saturating dispatch counters.
module escalonador_contexto #(
    parameter int NUM_PROC        = 8,
    parameter int PC_WIDTH        = 32,
    parameter int QUANTUM_WIDTH   = 8,
    parameter int QUANTUM_DEFAULT = 20,
    localparam int PW = $clog2(NUM_PROC)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [PC_WIDTH-1:0]      pc_atual,
    input  logic                     proc_create,
    input  logic [PW-1:0]            proc_create_id,
    input  logic [PC_WIDTH-1:0]      proc_create_pc,
    input  logic                     proc_end,
    input  logic                     io_req,
    input  logic                     io_done,
    input  logic [PW-1:0]            io_done_id,
    input  logic                     quantum_load,
    input  logic [QUANTUM_WIDTH-1:0] quantum_value,
    output logic                     troca_contexto,
    output logic [PC_WIDTH-1:0]      pc_destino,
    output logic [PW-1:0]            processo_atual,
    output logic                     ocioso,
    output logic [NUM_PROC-1:0]      slots_ativos,
    output logic                     erro_criacao
`ifdef ESCALONADOR_STATS_EN
    ,
    input  logic [PW-1:0]            stat_sel,
    input  logic                     stat_clear,
    output logic [15:0]              stat_despachos
`endif
);
    typedef enum logic [2:0] {OCIOSO, EXEC, SALVA, ESCOLHE, DESPACHA} fsm_t;
    typedef enum logic [1:0] {LIVRE, PRONTO, BLOQ, EXECUTANDO} slot_t;
    typedef enum logic [1:0] {C_FIM, C_IO, C_QUANTUM} causa_t;
    // Slot ids at or above NUM_PROC do not exist when NUM_PROC is not a power of two
    localparam logic [2**PW-1:0] EXISTE = {(2**PW){1'b1}} >> (2**PW - NUM_PROC);

    fsm_t                     fsm_q;
    slot_t                    st_q [NUM_PROC];
    logic [PC_WIDTH-1:0]      pc_q [NUM_PROC];
    logic [QUANTUM_WIDTH-1:0] quantum_q, cnt_q;
    logic [PW-1:0]            cur_q, prox_d, idx;
    logic [PC_WIDTH-1:0]      pc_destino_q, pc_salvo_q;
    logic                     troca_q, erro_q, achou_d, cria_ok, io_ok;
    causa_t                   causa_q;
    logic [NUM_PROC-1:0]      pronto, ativos;

    always_comb begin
        pronto = '0;
        ativos = '0;
        achou_d = 1'b0;
        prox_d = cur_q;
        idx = '0;
        for (int i = 0; i < NUM_PROC; i++) begin
            pronto[i] = st_q[i] == PRONTO;
            ativos[i] = st_q[i] != LIVRE;
        end
        // Descending scan so the nearest slot after cur_q wins; cur_q itself is tried last
        for (int k = NUM_PROC; k >= 1; k--) begin
            idx = PW'((int'(cur_q) + k) % NUM_PROC);
            if (pronto[idx]) begin
                achou_d = 1'b1;
                prox_d = idx;
            end
        end
        cria_ok = proc_create && EXISTE[proc_create_id] && st_q[proc_create_id] == LIVRE;
        io_ok = io_done && EXISTE[io_done_id] && (st_q[io_done_id] == BLOQ ||
                (fsm_q == SALVA && causa_q == C_IO && cur_q == io_done_id));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q <= OCIOSO;
            for (int i = 0; i < NUM_PROC; i++) begin
                st_q[i] <= LIVRE;
                pc_q[i] <= '0;
            end
            quantum_q <= QUANTUM_WIDTH'(QUANTUM_DEFAULT);
            cnt_q <= '0;
            cur_q <= '0;
            pc_destino_q <= '0;
            pc_salvo_q <= '0;
            troca_q <= 1'b0;
            erro_q <= 1'b0;
            causa_q <= C_QUANTUM;
        end else begin
            troca_q <= 1'b0;
            erro_q <= proc_create && !cria_ok;
            if (quantum_load)
                quantum_q <= (quantum_value == '0) ? QUANTUM_WIDTH'(1) : quantum_value;
            case (fsm_q)
                OCIOSO: if (|pronto) fsm_q <= ESCOLHE;
                EXEC: begin
                    if (enable) cnt_q <= cnt_q - QUANTUM_WIDTH'(1);
                    if (proc_end || io_req || (enable && cnt_q == QUANTUM_WIDTH'(1))) begin
                        fsm_q <= SALVA;
                        causa_q <= proc_end ? C_FIM : io_req ? C_IO : C_QUANTUM;
                        pc_salvo_q <= (io_req && !proc_end) ? pc_atual + PC_WIDTH'(1) : pc_atual;
                    end
                end
                SALVA: begin
                    st_q[cur_q] <= (causa_q == C_FIM) ? LIVRE : (causa_q == C_IO) ? BLOQ : PRONTO;
                    pc_q[cur_q] <= pc_salvo_q;
                    fsm_q <= ESCOLHE;
                end
                ESCOLHE: begin
                    fsm_q <= achou_d ? DESPACHA : OCIOSO;
                    if (achou_d) begin
                        troca_q <= 1'b1;
                        pc_destino_q <= pc_q[prox_d];
                        cur_q <= prox_d;
                    end
                end
                DESPACHA: begin
                    st_q[cur_q] <= EXECUTANDO;
                    cnt_q <= quantum_q;
                    fsm_q <= EXEC;
                end
                default: fsm_q <= OCIOSO;
            endcase
            if (cria_ok) begin
                st_q[proc_create_id] <= PRONTO;
                pc_q[proc_create_id] <= proc_create_pc;
            end
            // Placed after the SALVA write so a same-cycle completion leaves the slot ready
            if (io_ok) st_q[io_done_id] <= PRONTO;
        end
    end

    assign troca_contexto = troca_q;
    assign pc_destino = pc_destino_q;
    assign processo_atual = cur_q;
    assign ocioso = fsm_q == OCIOSO;
    assign slots_ativos = ativos;
    assign erro_criacao = erro_q;

`ifdef ESCALONADOR_STATS_EN
    logic [15:0] desp_q [NUM_PROC];

    always_ff @(posedge clock or posedge reset) begin
        if (reset || stat_clear) begin
            for (int i = 0; i < NUM_PROC; i++) desp_q[i] <= '0;
        end else if (fsm_q == DESPACHA && desp_q[cur_q] != 16'hFFFF) begin
            desp_q[cur_q] <= desp_q[cur_q] + 16'd1;
        end
    end

    assign stat_despachos = desp_q[stat_sel];
`endif
endmodule

// File: tb/tb_escalonador_contexto.sv
// tb_escalonador_contexto: directed scenarios plus a randomized run against a timeline reference model.
module tb_escalonador_contexto;
    localparam int NP = 8;
    localparam int FREE = 0, RDY = 1, BLK = 2, RUN = 3;

    logic        clock = 1'b0, reset = 1'b1, enable = 1'b0;
    logic [31:0] pc_atual = '0, proc_create_pc = '0;
    logic        proc_create = 1'b0, proc_end = 1'b0, io_req = 1'b0, io_done = 1'b0, quantum_load = 1'b0;
    logic [2:0]  proc_create_id = '0, io_done_id = '0;
    logic [7:0]  quantum_value = '0;
    logic        troca_contexto, ocioso, erro_criacao;
    logic [31:0] pc_destino;
    logic [2:0]  processo_atual;
    logic [7:0]  slots_ativos;
`ifdef ESCALONADOR_STATS_EN
    logic [2:0]  stat_sel = '0;
    logic        stat_clear = 1'b0;
    logic [15:0] stat_despachos;
`endif
    int checks = 0, failures = 0;

    always #5 clock = ~clock;

    escalonador_contexto dut (
        .clock(clock), .reset(reset), .enable(enable), .pc_atual(pc_atual),
        .proc_create(proc_create), .proc_create_id(proc_create_id), .proc_create_pc(proc_create_pc),
        .proc_end(proc_end), .io_req(io_req), .io_done(io_done), .io_done_id(io_done_id),
        .quantum_load(quantum_load), .quantum_value(quantum_value),
        .troca_contexto(troca_contexto), .pc_destino(pc_destino), .processo_atual(processo_atual),
        .ocioso(ocioso), .slots_ativos(slots_ativos), .erro_criacao(erro_criacao)
`ifdef ESCALONADOR_STATS_EN
        , .stat_sel(stat_sel), .stat_clear(stat_clear), .stat_despachos(stat_despachos)
`endif
    );

    task automatic clr();
        proc_create = 1'b0; proc_end = 1'b0; io_req = 1'b0; io_done = 1'b0; quantum_load = 1'b0;
    endtask

    task automatic do_reset();
        clr();
        enable = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic create(input logic [2:0] id, input logic [31:0] pc);
        proc_create = 1'b1; proc_create_id = id; proc_create_pc = pc;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({troca_contexto, ocioso, erro_criacao} !== 3'b010) begin
            failures++; $display("FAIL reset_flags got %b want 010", {troca_contexto, ocioso, erro_criacao});
        end
        checks++;
        if ({pc_destino, processo_atual, slots_ativos} !== 43'd0) begin
            failures++; $display("FAIL reset_values got pc=%h id=%0d act=%b want zeros", pc_destino, processo_atual, slots_ativos);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if ({troca_contexto, ocioso} !== 2'b01) begin
                failures++; $display("FAIL reset_idle k=%0d got %b want 01", k, {troca_contexto, ocioso});
            end
        end
    endtask

    task automatic test_create_dispatch();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({troca_contexto, ocioso} !== {k == 3, k <= 1}) begin
                failures++; $display("FAIL create_timing k=%0d got %b want %b", k, {troca_contexto, ocioso}, {k == 3, k <= 1});
            end
            if (k == 3) begin
                checks++;
                if ({pc_destino, processo_atual} !== {32'h40, 3'd0}) begin
                    failures++; $display("FAIL create_dest got pc=%h id=%0d want 40/0", pc_destino, processo_atual);
                end
            end
            if (k >= 1) begin
                checks++;
                if (slots_ativos !== 8'h01) begin
                    failures++; $display("FAIL create_mask k=%0d got %b want 00000001", k, slots_ativos);
                end
            end
            clr();
            if (k == 0) create(3'd0, 32'h40);
            @(negedge clock);
        end
    endtask

    task automatic test_round_robin();
        int          ks [4] = '{3, 10, 17, 24};
        logic [2:0]  ids [4] = '{3'd0, 3'd1, 3'd2, 3'd0};
        logic [31:0] pcs [4] = '{32'h100, 32'h200, 32'h300, 32'h507};
        do_reset();
        for (int k = 0; k < 27; k++) begin
            int s = -1;
            for (int j = 0; j < 4; j++) if (ks[j] == k) s = j;
            checks++;
            if (troca_contexto !== (s >= 0)) begin
                failures++; $display("FAIL rr_strobe k=%0d got %b want %b", k, troca_contexto, s >= 0);
            end
            if (s >= 0) begin
                checks++;
                if ({pc_destino, processo_atual} !== {pcs[s], ids[s]}) begin
                    failures++; $display("FAIL rr_dest k=%0d got pc=%h id=%0d want pc=%h id=%0d", k, pc_destino, processo_atual, pcs[s], ids[s]);
                end
            end
            clr();
            pc_atual = 32'h500 + 32'(k);
            if (k == 0) begin
                create(3'd0, 32'h100);
                quantum_load = 1'b1; quantum_value = 8'd4;
            end
            if (k == 2) create(3'd1, 32'h200);
            if (k == 3) create(3'd2, 32'h300);
            @(negedge clock);
        end
    endtask

    task automatic test_io();
        do_reset();
        for (int k = 0; k < 17; k++) begin
            checks++;
            if (troca_contexto !== (k == 3 || k == 8 || k == 15)) begin
                failures++; $display("FAIL io_strobe k=%0d got %b", k, troca_contexto);
            end
            if (k == 3 || k == 8 || k == 15) begin
                logic [34:0] want;
                want = (k == 3) ? {32'h80, 3'd1} : (k == 8) ? {32'h90, 3'd2} : {32'h81, 3'd1};
                checks++;
                if ({pc_destino, processo_atual} !== want) begin
                    failures++; $display("FAIL io_dest k=%0d got pc=%h id=%0d want %h", k, pc_destino, processo_atual, want);
                end
            end
            if (k == 7 || k == 15) begin
                checks++;
                if (slots_ativos !== ((k == 7) ? 8'h06 : 8'h02)) begin
                    failures++; $display("FAIL io_mask k=%0d got %b", k, slots_ativos);
                end
            end
            clr();
            pc_atual = (k == 5) ? 32'h80 : 32'h1000 + 32'(k);
            if (k == 0) create(3'd1, 32'h80);
            if (k == 2) create(3'd2, 32'h90);
            if (k == 5) io_req = 1'b1;
            if (k == 9) begin io_done = 1'b1; io_done_id = 3'd1; end
            if (k == 12) proc_end = 1'b1;
            @(negedge clock);
        end
    endtask

    task automatic test_proc_end();
        do_reset();
        for (int k = 0; k < 11; k++) begin
            checks++;
            if ({troca_contexto, ocioso} !== {k == 3, k <= 1 || k >= 8}) begin
                failures++; $display("FAIL end_flags k=%0d got %b", k, {troca_contexto, ocioso});
            end
            checks++;
            if (slots_ativos !== ((k >= 1 && k <= 6) ? 8'h08 : 8'h00)) begin
                failures++; $display("FAIL end_mask k=%0d got %b", k, slots_ativos);
            end
            if (k == 3) begin
                checks++;
                if ({pc_destino, processo_atual} !== {32'h30, 3'd3}) begin
                    failures++; $display("FAIL end_dest got pc=%h id=%0d want 30/3", pc_destino, processo_atual);
                end
            end
            clr();
            if (k == 0) create(3'd3, 32'h30);
            if (k == 5) proc_end = 1'b1;
            @(negedge clock);
        end
    endtask

    task automatic test_create_error();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({erro_criacao, troca_contexto} !== {k == 2, k == 3}) begin
                failures++; $display("FAIL err_flags k=%0d got %b", k, {erro_criacao, troca_contexto});
            end
            if (k == 3) begin
                checks++;
                if (pc_destino !== 32'h22) begin
                    failures++; $display("FAIL err_pc got %h want 22", pc_destino);
                end
            end
            if (k >= 1) begin
                checks++;
                if (slots_ativos !== 8'h04) begin
                    failures++; $display("FAIL err_mask k=%0d got %b", k, slots_ativos);
                end
            end
            clr();
            if (k == 0) create(3'd2, 32'h22);
            if (k == 1) create(3'd2, 32'h99);
            @(negedge clock);
        end
    endtask

    task automatic test_reset_mid_switch();
        do_reset();
        create(3'd5, 32'h40);
        @(negedge clock);
        clr();
        repeat (2) @(negedge clock);
        checks++;
        if ({troca_contexto, processo_atual} !== {1'b1, 3'd5}) begin
            failures++; $display("FAIL mid_pre got %b id=%0d want strobe on slot 5", troca_contexto, processo_atual);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({troca_contexto, ocioso, erro_criacao, pc_destino, processo_atual, slots_ativos} !== {3'b010, 43'd0}) begin
            failures++; $display("FAIL mid_reset got t=%b o=%b pc=%h id=%0d act=%b", troca_contexto, ocioso, pc_destino, processo_atual, slots_ativos);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if ({troca_contexto, ocioso, slots_ativos} !== {2'b01, 8'h00}) begin
                failures++; $display("FAIL mid_after k=%0d got t=%b o=%b act=%b", k, troca_contexto, ocioso, slots_ativos);
            end
        end
    endtask

    task automatic test_random();
        int          mst [NP], nst [NP];
        logic [31:0] mpc [NP];
        logic [31:0] mdst, spc;
        logic [7:0]  ea;
        int          mcur, mq, rem, cause, save_at, pick_at, strobe_at, found;
        bit          run, idle, nidle, merro, nerro, anyr;
        do_reset();
        for (int i = 0; i < NP; i++) begin mst[i] = FREE; mpc[i] = '0; end
        mdst = '0; spc = '0; mcur = 0; mq = 20; rem = 0; cause = 0;
        save_at = -1; pick_at = -1; strobe_at = -1;
        run = 0; idle = 1; merro = 0;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < NP; i++) ea[i] = mst[i] != FREE;
            checks++;
            if (troca_contexto !== (strobe_at == t)) begin
                failures++; $display("FAIL rnd_strobe t=%0d got %b want %b", t, troca_contexto, strobe_at == t);
            end
            checks++;
            if (ocioso !== idle) begin
                failures++; $display("FAIL rnd_idle t=%0d got %b want %b", t, ocioso, idle);
            end
            checks++;
            if (erro_criacao !== merro) begin
                failures++; $display("FAIL rnd_err t=%0d got %b want %b", t, erro_criacao, merro);
            end
            checks++;
            if (slots_ativos !== ea) begin
                failures++; $display("FAIL rnd_mask t=%0d got %b want %b", t, slots_ativos, ea);
            end
            checks++;
            if (processo_atual !== 3'(mcur)) begin
                failures++; $display("FAIL rnd_cur t=%0d got %0d want %0d", t, processo_atual, mcur);
            end
            checks++;
            if (pc_destino !== mdst) begin
                failures++; $display("FAIL rnd_pc t=%0d got %h want %h", t, pc_destino, mdst);
            end
            clr();
            enable = $urandom_range(0, 99) < 85;
            pc_atual = $urandom();
            if ($urandom_range(0, 99) < 15) create(3'($urandom_range(0, 7)), $urandom());
            proc_end = $urandom_range(0, 99) < 3;
            io_req = $urandom_range(0, 99) < 6;
            io_done = $urandom_range(0, 99) < 15;
            io_done_id = 3'($urandom_range(0, 7));
            quantum_load = $urandom_range(0, 99) < 3;
            quantum_value = 8'($urandom_range(0, 6));
            // Reference: a preemption at t saves at t+1, picks at t+2, strobes at t+3
            nst = mst;
            nidle = idle;
            nerro = 0;
            if (run) begin
                if (proc_end || io_req || (enable && rem == 1)) begin
                    cause = proc_end ? 0 : io_req ? 1 : 2;
                    spc = (io_req && !proc_end) ? pc_atual + 32'd1 : pc_atual;
                    run = 0; save_at = t + 1; pick_at = t + 2;
                end else if (enable) rem--;
            end
            if (t == save_at) begin
                nst[mcur] = (cause == 0) ? FREE : (cause == 1) ? BLK : RDY;
                mpc[mcur] = spc;
            end
            if (t == strobe_at) begin nst[mcur] = RUN; rem = mq; run = 1; end
            if (t == pick_at) begin
                found = -1;
                for (int k = 1; k <= NP; k++) if (found < 0 && mst[(mcur + k) % NP] == RDY) found = (mcur + k) % NP;
                if (found >= 0) begin mcur = found; mdst = mpc[found]; strobe_at = t + 1; end
                else nidle = 1;
            end
            anyr = 0;
            for (int i = 0; i < NP; i++) if (mst[i] == RDY) anyr = 1;
            if (idle && anyr) begin nidle = 0; pick_at = t + 1; end
            if (proc_create) begin
                if (mst[proc_create_id] == FREE) begin nst[proc_create_id] = RDY; mpc[proc_create_id] = proc_create_pc; end
                else nerro = 1;
            end
            if (io_done && (mst[io_done_id] == BLK || (t == save_at && cause == 1 && int'(io_done_id) == mcur)))
                nst[io_done_id] = RDY;
            if (quantum_load) mq = (quantum_value == 0) ? 1 : int'(quantum_value);
            mst = nst;
            idle = nidle;
            merro = nerro;
            @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_create_dispatch();
        test_round_robin();
        test_io();
        test_proc_end();
        test_create_error();
        test_reset_mid_switch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/escalonador_contexto.md
Name: escalonador_contexto

Overview:
Parametrised hardware round-robin scheduler and context table for the multi-process CPU, generalising the fixed quantum counter.
- Holds a saved PC and a state for each of NUM_PROC process slots.
- Preempts the running process on quantum expiry, an IO instruction or process end, then selects the next ready slot.
- Drives the CPU PC mux with a one-cycle context-switch strobe and the destination PC.

Parameters:
NUM_PROC, 8, number of process slots (2..16); ID width PW = clog2(NUM_PROC)
PC_WIDTH, 32, width of PC values
QUANTUM_WIDTH, 8, quantum counter width
QUANTUM_DEFAULT, 20, quantum in enabled cycles after reset

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  CPU not halted; quantum counts only when 1
pc_atual  in  PC_WIDTH  PC of the running instruction
proc_create  in  1  pulse: load a slot
proc_create_id  in  PW  slot to load
proc_create_pc  in  PC_WIDTH  start PC for the new slot
proc_end  in  1  pulse: running process finished
io_req  in  1  pulse: running process issued an IO instruction
io_done  in  1  pulse: IO complete
io_done_id  in  PW  slot whose IO completed
quantum_load  in  1  pulse: replace the quantum
quantum_value  in  QUANTUM_WIDTH  new quantum (0 is treated as 1)
troca_contexto  out  1  one-cycle strobe: CPU loads pc_destino
pc_destino  out  PC_WIDTH  PC to load on the strobe
processo_atual  out  PW  running slot
ocioso  out  1  no process is ready
slots_ativos  out  NUM_PROC  valid mask
erro_criacao  out  1  one-cycle strobe: create was rejected

Behaviour:
- Per-slot state: LIVRE, PRONTO, BLOQ (waiting on IO), EXEC.
- Reset values:
  - All slots LIVRE, pc table 0, quantum = QUANTUM_DEFAULT.
  - FSM in OCIOSO; ocioso = 1.
  - troca_contexto, pc_destino, processo_atual, slots_ativos, erro_criacao all 0.
- Reset is honoured in any state, including mid-switch; no strobe is emitted in the reset cycle.
- FSM states:
  - OCIOSO: wait for any PRONTO slot, then go to ESCOLHE.
  - EXEC: the counter decrements on each enable cycle. Go to SALVA when any of these holds:
    - proc_end
    - io_req
    - counter == 1 while enable = 1
  - SALVA (1 cycle). Cause priority: proc_end > io_req > expiry.
    - proc_end: slot becomes LIVRE.
    - io_req: slot becomes BLOQ; save pc_atual + 1 (wraps mod 2^PC_WIDTH).
    - expiry: slot becomes PRONTO; save pc_atual.
  - ESCOLHE (1 cycle): round-robin search over PRONTO slots, starting at processo_atual+1 and wrapping modulo NUM_PROC.
    - The current slot is chosen last.
    - If nothing is PRONTO, go to OCIOSO.
  - DESPACHA (1 cycle):
    - troca_contexto = 1; pc_destino = table[next]; processo_atual = next.
    - Slot becomes EXEC; counter reloads the quantum; next state is EXEC.
- Latency: an event sampled in EXEC cycle N gives troca_contexto high in cycle N+3. From OCIOSO, a slot turning PRONTO in cycle N gives the strobe in cycle N+2.
- pc_destino holds its value between strobes.
- Events (proc_end, io_req, expiry) are ignored outside EXEC.
- proc_create:
  - Accepted only if the target slot is LIVRE: store the PC, slot becomes PRONTO, visible the next cycle.
  - Otherwise pulse erro_criacao and change nothing.
- io_done:
  - Moves a BLOQ slot to PRONTO.
  - Ignored for slots in any other state.
  - If it coincides with SALVA blocking the same slot, the SALVA transition is applied first, then io_done, so the slot ends PRONTO.
- quantum_load takes effect at the next reload; the running count is unaffected.
- slots_ativos bit i = 1 when slot i is not LIVRE.
- ocioso = 1 exactly in state OCIOSO.

Optional Feature:
ESCALONADOR_STATS_EN
- Defined: adds inputs stat_sel (PW) and stat_clear (1), and output stat_despachos (16 bits).
  - One 16-bit per-slot dispatch counter, incremented in DESPACHA; it saturates at 0xFFFF.
  - stat_despachos = counter[stat_sel], combinational.
  - stat_clear zeroes all counters synchronously.
  - reset zeroes all counters.
- Undefined: none of these ports or counters exist; all other behaviour is identical.

Test Plan:
- Reset, then create slot 0 at PC 0x40 -> ocioso drops and troca_contexto pulses 2 cycles later with pc_destino = 0x40 and processo_atual = 0.
- Slots 0, 1, 2 created, quantum 4, enable = 1 throughout -> dispatch order 0, 1, 2, 0, with a strobe every 7 cycles; slot 0 resumes at its saved pc_atual.
- Running slot 1 at PC 0x80 asserts io_req -> slot 1 BLOQ, next slot dispatched; io_done with id 1 -> slot 1 later resumes at 0x81.
- Only slot 3 valid; proc_end -> slot becomes LIVRE, ocioso = 1, slots_ativos = 0, no strobe.
- Create into an occupied slot 2 -> erro_criacao pulses once, and slot 2's PC and state are unchanged.
- Assert reset during DESPACHA -> no strobe; all outputs return to their reset values.
